// File: rtl/dht_poll_scheduler.sv
// dht_poll_scheduler
//   Schedules DHT11 measurement sessions on the single-wire reader: periodic
//   triggers, retry after a failed session, per-session timeout and a
//   gap-limited forced measurement. Publishes the last good temperature and
//   humidity with a valid pulse, a stale flag and an error pulse.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   enable               level, 1 = scheduling active
//   force_req            pulse, request an immediate measurement
//   meas_start           one-cycle pulse to the reader: begin session
//   meas_done/meas_ok    one-cycle completion pulse and checksum-good qualifier
//   meas_temp/meas_hum   reader bytes, valid with meas_done
//   temp/hum             last good reading
//   data_valid           one-cycle pulse, temp/hum updated
//   stale                no good reading since reset, or last session failed
//   err                  one-cycle pulse, session failed after all retries
//   busy                 session outstanding
//   ok_cnt/fail_cnt      session statistics
//
// Build option
//   DHT_SCHED_STATS_EN   when defined, ok_cnt/fail_cnt count data_valid/err
//                        pulses (saturating); otherwise both are tied to 0.

module dht_poll_scheduler #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned PERIOD_MS  = 2000,
  parameter int unsigned RETRY_MS   = 1100,
  parameter int unsigned TIMEOUT_MS = 50,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned MIN_GAP_MS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        force_req,
  output logic        meas_start,
  input  logic        meas_done,
  input  logic        meas_ok,
  input  logic [7:0]  meas_temp,
  input  logic [7:0]  meas_hum,
  output logic [7:0]  temp,
  output logic [7:0]  hum,
  output logic        data_valid,
  output logic        stale,
  output logic        err,
  output logic        busy,
  output logic [15:0] ok_cnt,
  output logic [15:0] fail_cnt
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_MS = max2(max2(PERIOD_MS, RETRY_MS), max2(TIMEOUT_MS, MIN_GAP_MS));
  localparam int unsigned CW     = $clog2(MAX_MS + 1);
  localparam int unsigned DW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [CW-1:0] PERIOD_C  = CW'(PERIOD_MS);
  localparam logic [CW-1:0] RETRY_C   = CW'(RETRY_MS);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_MS);
  localparam logic [CW-1:0] MIN_GAP_C = CW'(MIN_GAP_MS);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_BUSY
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [CW-1:0] gap_q, gap_d;
  logic [CW-1:0] to_q, to_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          pend_q, pend_d;
  logic [7:0]    temp_q, temp_d;
  logic [7:0]    hum_q, hum_d;
  logic          data_valid_q, data_valid_d;
  logic          err_q, err_d;
  logic          stale_q, stale_d;
  logic          tick;
  logic          timeout_hit;

  assign tick = (div_q == DIV_LAST);

  // Timeout fires on the tick that would bring the counter up to the limit,
  // so a meas_done on that same tick can still take precedence.
  assign timeout_hit = tick && (({1'b0, to_q} + 1'b1) >= {1'b0, TIMEOUT_C});

  always_comb begin
    state_d      = state_q;
    div_d        = tick ? '0 : div_q + 1'b1;
    wait_d       = wait_q;
    gap_d        = gap_q;
    to_d         = to_q;
    retry_d      = retry_q;
    pend_d       = pend_q;
    temp_d       = temp_q;
    hum_d        = hum_q;
    data_valid_d = 1'b0;
    err_d        = 1'b0;
    stale_d      = stale_q;

    if (tick && (gap_q < MIN_GAP_C)) begin
      gap_d = gap_q + 1'b1;
    end

    if (!enable) begin
      // Abandon any session; a late meas_done is ignored because BUSY is left.
      state_d = S_IDLE;
      pend_d  = 1'b0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          wait_d  = PERIOD_C;
        end

        S_WAIT: begin
          if (force_req) begin
            pend_d = 1'b1;
          end
          if (tick && (wait_q != '0)) begin
            wait_d = wait_q - 1'b1;
          end
          if ((wait_q == '0) || (tick && (wait_q == ONE_C)) ||
              (pend_q && (gap_q >= MIN_GAP_C))) begin
            state_d = S_START;
          end
        end

        S_START: begin
          pend_d  = 1'b0;
          gap_d   = '0;
          to_d    = '0;
          state_d = S_BUSY;
        end

        S_BUSY: begin
          if (force_req) begin
            pend_d = 1'b1;
          end
          if (tick && (to_q < TIMEOUT_C)) begin
            to_d = to_q + 1'b1;
          end
          if (meas_done && meas_ok) begin
            temp_d       = meas_temp;
            hum_d        = meas_hum;
            data_valid_d = 1'b1;
            stale_d      = 1'b0;
            retry_d      = '0;
            wait_d       = PERIOD_C;
            state_d      = S_WAIT;
          end else if (meas_done || timeout_hit) begin
            if (retry_q < RETRY_LIM) begin
              retry_d = retry_q + 1'b1;
              wait_d  = RETRY_C;
            end else begin
              err_d   = 1'b1;
              stale_d = 1'b1;
              retry_d = '0;
              wait_d  = PERIOD_C;
            end
            state_d = S_WAIT;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      wait_q       <= '0;
      gap_q        <= MIN_GAP_C;
      to_q         <= '0;
      retry_q      <= '0;
      pend_q       <= 1'b0;
      temp_q       <= '0;
      hum_q        <= '0;
      data_valid_q <= 1'b0;
      err_q        <= 1'b0;
      stale_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      wait_q       <= wait_d;
      gap_q        <= gap_d;
      to_q         <= to_d;
      retry_q      <= retry_d;
      pend_q       <= pend_d;
      temp_q       <= temp_d;
      hum_q        <= hum_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
      stale_q      <= stale_d;
    end
  end

  assign meas_start = (state_q == S_START);
  assign busy       = (state_q == S_BUSY);
  assign temp       = temp_q;
  assign hum        = hum_q;
  assign data_valid = data_valid_q;
  assign err        = err_q;
  assign stale      = stale_q;

`ifdef DHT_SCHED_STATS_EN
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    ok_cnt_d   = ok_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (data_valid_d && (ok_cnt_q != '1)) begin
      ok_cnt_d = ok_cnt_q + 1'b1;
    end
    if (err_d && (fail_cnt_q != '1)) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt_q   <= '0;
      fail_cnt_q <= '0;
    end else begin
      ok_cnt_q   <= ok_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign ok_cnt   = ok_cnt_q;
  assign fail_cnt = fail_cnt_q;
`else
  assign ok_cnt   = '0;
  assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_dht_poll_scheduler.sv
// Directed bench for dht_poll_scheduler with small timing parameters
// (1 ms = 10 clk). Cycle numbers below count rising edges since the last
// reset release; ticks land on multiples of 10.

module tb_dht_poll_scheduler;

`ifdef DHT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        force_req;
  logic        meas_start;
  logic        meas_done;
  logic        meas_ok;
  logic [7:0]  meas_temp;
  logic [7:0]  meas_hum;
  logic [7:0]  temp;
  logic [7:0]  hum;
  logic        data_valid;
  logic        stale;
  logic        err;
  logic        busy;
  logic [15:0] ok_cnt;
  logic [15:0] fail_cnt;

  int cyc;
  int n_checks = 0;
  int n_pass   = 0;
  int dv_cnt   = 0;
  int err_cnt  = 0;
  int st_cnt   = 0;

  dht_poll_scheduler #(
    .TICK_DIV  (10),
    .PERIOD_MS (20),
    .RETRY_MS  (5),
    .TIMEOUT_MS(8),
    .MAX_RETRY (2),
    .MIN_GAP_MS(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .force_req (force_req),
    .meas_start(meas_start),
    .meas_done (meas_done),
    .meas_ok   (meas_ok),
    .meas_temp (meas_temp),
    .meas_hum  (meas_hum),
    .temp      (temp),
    .hum       (hum),
    .data_valid(data_valid),
    .stale     (stale),
    .err       (err),
    .busy      (busy),
    .ok_cnt    (ok_cnt),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (data_valid) dv_cnt  <= dv_cnt + 1;
    if (err)        err_cnt <= err_cnt + 1;
    if (meas_start) st_cnt  <= st_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Returns the cycle of the next meas_start, or -1 if none within limit.
  task automatic wait_start(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (meas_start) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic pulse_done(input logic ok, input logic [7:0] t, input logic [7:0] h);
    meas_done = 1'b1;
    meas_ok   = ok;
    meas_temp = t;
    meas_hum  = h;
    @(negedge clk);
    meas_done = 1'b0;
    meas_ok   = 1'b0;
  endtask

  task automatic serve(input int dly, input logic ok, input logic [7:0] t, input logic [7:0] h);
    repeat (dly) @(negedge clk);
    pulse_done(ok, t, h);
  endtask

  initial begin
    int s;
    int dv0, err0, st0;

    rst = 1'b1; enable = 1'b0; force_req = 1'b0;
    meas_done = 1'b0; meas_ok = 1'b0; meas_temp = '0; meas_hum = '0;
    repeat (3) @(negedge clk);
    check("rst_stale", stale, 1);
    check("rst_temp", temp, 0);
    check("rst_hum", hum, 0);
    check("rst_busy", busy, 0);
    check("rst_start", meas_start, 0);
    check("rst_dv", data_valid, 0);
    check("rst_err", err, 0);
    check("rst_ok_cnt", ok_cnt, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    rst = 1'b0; enable = 1'b1;

    // Nominal
    wait_start(400, s);
    check("start1", s, 200);
    @(negedge clk);
    check("start_one_cycle", meas_start, 0);
    check("busy", busy, 1);
    serve(29, 1'b1, 8'd23, 8'd45);
    check("nom_dv", data_valid, 1);
    check("nom_temp", temp, 23);
    check("nom_hum", hum, 45);
    check("nom_stale", stale, 0);
    check("nom_busy", busy, 0);
    check("nom_ok_cnt", ok_cnt, STATS ? 1 : 0);
    @(negedge clk);
    check("nom_dv_pulse", data_valid, 0);
    wait_start(400, s);
    check("period_start", s, 430);

    // Bad checksum x3
    serve(30, 1'b0, 8'd77, 8'd88);
    check("bad1_err", err, 0);
    check("bad1_stale", stale, 0);
    wait_start(400, s);
    check("retry1_start", s, 510);
    serve(30, 1'b0, 8'd77, 8'd88);
    wait_start(400, s);
    check("retry2_start", s, 590);
    serve(30, 1'b0, 8'd77, 8'd88);
    check("bad_err", err, 1);
    check("bad_stale", stale, 1);
    check("bad_temp", temp, 23);
    check("bad_hum", hum, 45);
    check("bad_dv", data_valid, 0);
    check("bad_fail_cnt", fail_cnt, STATS ? 1 : 0);
    wait_start(400, s);
    check("after_fail_start", s, 820);

    // Timeout x3
    err0 = err_cnt;
    wait_start(400, s);
    check("to_retry1", s, 950);
    wait_start(400, s);
    check("to_retry2", s, 1080);
    check("to_no_early_err", err_cnt, err0);
    repeat (80) @(negedge clk);
    check("to_err", err, 1);
    wait_start(400, s);
    check("to_after_err", s, 1360);
    serve(79, 1'b1, 8'd50, 8'd60);
    check("done_on_to_dv", data_valid, 1);
    check("done_on_to_err", err, 0);
    check("done_on_to_temp", temp, 50);
    check("done_on_to_hum", hum, 60);
    check("done_on_to_stale", stale, 0);
    wait_start(400, s);
    check("done_on_to_next", s, 1640);

    // force_req after a good read, deferred by the gap
    serve(30, 1'b1, 8'd24, 8'd46);
    check("f_temp", temp, 24);
    repeat (20) @(negedge clk);
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    wait_start(400, s);
    check("force_gap_start", s, 1741);

    // force_req during BUSY
    repeat (5) @(negedge clk);
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    serve(23, 1'b1, 8'd25, 8'd47);
    check("fb_dv", data_valid, 1);
    wait_start(400, s);
    check("force_busy_start", s, 1841);

    // Abort mid-BUSY
    repeat (10) @(negedge clk);
    dv0 = dv_cnt; err0 = err_cnt; st0 = st_cnt;
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    pulse_done(1'b1, 8'd99, 8'd99);
    repeat (44) @(negedge clk);
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
    repeat (94) @(negedge clk);
    check("abort_cyc", cyc, 1995);
    check("abort_temp", temp, 25);
    check("abort_hum", hum, 47);
    check("abort_stale", stale, 0);
    check("abort_no_dv", dv_cnt, dv0);
    check("abort_no_err", err_cnt, err0);
    check("abort_no_start", st_cnt, st0);
    check("abort_ok_cnt", ok_cnt, STATS ? 4 : 0);
    check("abort_fail_cnt", fail_cnt, STATS ? 2 : 0);
    enable = 1'b1;
    wait_start(400, s);
    check("reenable_start", s, 2190);

    // Async reset mid-WAIT
    serve(30, 1'b1, 8'd26, 8'd48);
    check("pre_rst_temp", temp, 26);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_stale", stale, 1);
    check("arst_temp", temp, 0);
    check("arst_hum", hum, 0);
    check("arst_busy", busy, 0);
    check("arst_ok_cnt", ok_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_start(400, s);
    check("post_rst_start", s, 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
